// File: rtl/seven_segment_if.sv
// -----------------------------------------------------------------------------
// seven_segment_if
//
// Purpose:
//   Bundles the digit-code inputs and the segment outputs of one seven-segment
//   digit. The upstream digit-selection/counter logic is the master. The
//   decoder is the slave.
//
// Signals:
//   en          update enable (master -> slave)
//   s3..s0      4-bit digit code, s3 = MSB (master -> slave)
//   a..g        segment lines, physical polarity (slave -> master)
// -----------------------------------------------------------------------------
interface seven_segment_if;
  logic en;
  logic s3;
  logic s2;
  logic s1;
  logic s0;
  logic a;
  logic b;
  logic c;
  logic d;
  logic e;
  logic f;
  logic g;

  modport master (
    output en, s3, s2, s1, s0,
    input  a, b, c, d, e, f, g
  );

  modport slave (
    input  en, s3, s2, s1, s0,
    output a, b, c, d, e, f, g
  );
endinterface

// File: rtl/seven_segment.sv
// -----------------------------------------------------------------------------
// seven_segment
//
// Purpose:
//   Registered BCD/hex to seven-segment decoder for one display digit. The
//   4-bit code on s3..s0 is decoded combinationally. The result is registered
//   on the rising clk edge while en is high, so the display pins change only
//   on clock edges.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous, active-high reset
//   bus         seven_segment_if.slave: en, s3..s0 in; a..g out
//
// Parameters:
//   ACTIVE_LOW  0 = lit segment drives 1 (common cathode)
//               1 = all outputs inverted (common anode)
//   RESET_BLANK 1 = all segments off after reset
//               0 = reset shows the digit-0 pattern
//
// Build option:
//   SEVENSEG_HEX_EN  when defined, codes 10-15 show the hex glyphs A b C d E F.
//                    When undefined, those codes are blanked.
// -----------------------------------------------------------------------------
module seven_segment #(
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter bit RESET_BLANK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  seven_segment_if.slave  bus
);

  // Logical patterns are ordered {a,b,c,d,e,f,g}. A 1 means the segment is lit.
  localparam logic [6:0] SEG_BLANK = 7'b000_0000;
  localparam logic [6:0] SEG_0     = 7'b111_1110;

  // Polarity is folded in before the register. This keeps the pins driven
  // straight from flops and applies the inversion to the reset value as well.
  localparam logic [6:0] POL_MASK  = {7{ACTIVE_LOW}};
  localparam logic [6:0] RST_VALUE = (RESET_BLANK ? SEG_BLANK : SEG_0) ^ POL_MASK;

  logic [3:0] code;
  logic [6:0] pattern;   // logical decode of the current code
  logic [6:0] seg_d;
  logic [6:0] seg_q;     // physical pattern currently on the pins

  assign code = {bus.s3, bus.s2, bus.s1, bus.s0};

  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'd0:  pattern = 7'b111_1110;
      4'd1:  pattern = 7'b011_0000;
      4'd2:  pattern = 7'b110_1101;
      4'd3:  pattern = 7'b111_1001;
      4'd4:  pattern = 7'b011_0011;
      4'd5:  pattern = 7'b101_1011;
      4'd6:  pattern = 7'b101_1111;
      4'd7:  pattern = 7'b111_0000;
      4'd8:  pattern = 7'b111_1111;
      4'd9:  pattern = 7'b111_1011;
`ifdef SEVENSEG_HEX_EN
      4'd10: pattern = 7'b111_0111;  // A
      4'd11: pattern = 7'b001_1111;  // b
      4'd12: pattern = 7'b100_1110;  // C
      4'd13: pattern = 7'b011_1101;  // d
      4'd14: pattern = 7'b100_1111;  // E
      4'd15: pattern = 7'b100_0111;  // F
`else
      // Decimal-only build: codes that are not valid digits show nothing.
      default: pattern = SEG_BLANK;
`endif
    endcase
  end

  // Hold the current pins while en is low.
  always_comb begin
    seg_d = seg_q;
    if (bus.en) begin
      seg_d = pattern ^ POL_MASK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= RST_VALUE;
    end else begin
      seg_q <= seg_d;
    end
  end

  assign bus.a = seg_q[6];
  assign bus.b = seg_q[5];
  assign bus.c = seg_q[4];
  assign bus.d = seg_q[3];
  assign bus.e = seg_q[2];
  assign bus.f = seg_q[1];
  assign bus.g = seg_q[0];

endmodule

// File: tb/tb_seven_segment.sv
// -----------------------------------------------------------------------------
// tb_seven_segment
//
// Three decoders share clk/rst and the same stimulus:
//   u_cc   ACTIVE_LOW=0, RESET_BLANK=1 (defaults)
//   u_ca   ACTIVE_LOW=1, RESET_BLANK=1
//   u_rz   ACTIVE_LOW=0, RESET_BLANK=0
// Expected values are logical patterns taken from the digit table. The
// common-anode instance is expected to show the bitwise inverse.
// -----------------------------------------------------------------------------
module tb_seven_segment;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  seven_segment_if if_cc ();
  seven_segment_if if_ca ();
  seven_segment_if if_rz ();

  seven_segment #(.ACTIVE_LOW(1'b0), .RESET_BLANK(1'b1)) u_cc (
    .clk(clk), .rst(rst), .bus(if_cc.slave)
  );
  seven_segment #(.ACTIVE_LOW(1'b1), .RESET_BLANK(1'b1)) u_ca (
    .clk(clk), .rst(rst), .bus(if_ca.slave)
  );
  seven_segment #(.ACTIVE_LOW(1'b0), .RESET_BLANK(1'b0)) u_rz (
    .clk(clk), .rst(rst), .bus(if_rz.slave)
  );

  typedef struct {
    logic [3:0] n;
    logic       en;
    logic [6:0] exp;   // logical pattern expected after the next edge
  } vec_t;

  vec_t vecs [0:63];
  int   nvec = 0;
  int   tests = 0;
  int   fails = 0;

  function automatic logic [6:0] seg_of(input logic a, b, c, d, e, f, g);
    return {a, b, c, d, e, f, g};
  endfunction

  task automatic add_vec(input logic [3:0] n, input logic en, input logic [6:0] exp);
    vecs[nvec].n   = n;
    vecs[nvec].en  = en;
    vecs[nvec].exp = exp;
    nvec++;
  endtask

  task automatic drive(input logic [3:0] n, input logic en);
    {if_cc.s3, if_cc.s2, if_cc.s1, if_cc.s0} = n;
    {if_ca.s3, if_ca.s2, if_ca.s1, if_ca.s0} = n;
    {if_rz.s3, if_rz.s2, if_rz.s1, if_rz.s0} = n;
    if_cc.en = en;
    if_ca.en = en;
    if_rz.en = en;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [6:0] act,
                       input logic [6:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got %b want %b", name, idx, act, exp);
    end else begin
      $display("ok   %s[%0d] = %b", name, idx, act);
    end
  endtask

  // Checks all three instances against one logical pattern. The
  // RESET_BLANK=0 instance gets its own expectation, because only the reset
  // value differs between the instances.
  task automatic check_all(input string name, input int idx, input logic [6:0] exp,
                           input logic [6:0] exp_rz);
    check({name, "_cc"}, idx,
          seg_of(if_cc.a, if_cc.b, if_cc.c, if_cc.d, if_cc.e, if_cc.f, if_cc.g), exp);
    check({name, "_ca"}, idx,
          seg_of(if_ca.a, if_ca.b, if_ca.c, if_ca.d, if_ca.e, if_ca.f, if_ca.g), ~exp);
    check({name, "_rz"}, idx,
          seg_of(if_rz.a, if_rz.b, if_rz.c, if_rz.d, if_rz.e, if_rz.f, if_rz.g), exp_rz);
  endtask

  localparam logic [6:0] D0 = 7'b1111110;
  localparam logic [6:0] D1 = 7'b0110000;
  localparam logic [6:0] D2 = 7'b1101101;
  localparam logic [6:0] D8 = 7'b1111111;
  localparam logic [6:0] BL = 7'b0000000;

  logic [6:0] dec_tab [0:9];
  logic [6:0] hex_tab [10:15];

  initial begin
    dec_tab[0] = 7'b1111110; dec_tab[1] = 7'b0110000; dec_tab[2] = 7'b1101101;
    dec_tab[3] = 7'b1111001; dec_tab[4] = 7'b0110011; dec_tab[5] = 7'b1011011;
    dec_tab[6] = 7'b1011111; dec_tab[7] = 7'b1110000; dec_tab[8] = 7'b1111111;
    dec_tab[9] = 7'b1111011;
`ifdef SEVENSEG_HEX_EN
    hex_tab[10] = 7'b1110111; hex_tab[11] = 7'b0011111; hex_tab[12] = 7'b1001110;
    hex_tab[13] = 7'b0111101; hex_tab[14] = 7'b1001111; hex_tab[15] = 7'b1000111;
`else
    for (int i = 10; i <= 15; i++) hex_tab[i] = 7'b0000000;
`endif

    // Full decimal sweep.
    for (int i = 0; i <= 9; i++) add_vec(4'(i), 1'b1, dec_tab[i]);
    // Run 0..8, then back to 1.
    for (int i = 0; i <= 8; i++) add_vec(4'(i), 1'b1, dec_tab[i]);
    add_vec(4'd1, 1'b1, D1);
    // Hold: register 8, drop en with code 1 for three cycles, then raise en.
    add_vec(4'd8, 1'b1, D8);
    add_vec(4'd1, 1'b0, D8);
    add_vec(4'd1, 1'b0, D8);
    add_vec(4'd1, 1'b0, D8);
    add_vec(4'd1, 1'b1, D1);
    // Codes 10-15.
    for (int i = 10; i <= 15; i++) add_vec(4'(i), 1'b1, hex_tab[i]);
    // While en is low, a hex/blank code must not disturb a held digit.
    add_vec(4'd2, 1'b1, D2);
    add_vec(4'd15, 1'b0, D2);

    // Let the clock run, then assert reset halfway between edges.
    drive(4'd5, 1'b0);
    step();
    step();
    #3;
    rst = 1'b1;
    #1;
    check_all("rst_async", 0, BL, D0);
    step();
    step();
    check_all("rst_held", 0, BL, D0);

    // Release reset between edges. Code 0 appears one edge later.
    #2;
    rst = 1'b0;
    drive(4'd0, 1'b1);
    check_all("rst_release", 0, BL, D0);
    step();
    check_all("first_d0", 0, D0, D0);

    for (int i = 0; i < nvec; i++) begin
      drive(vecs[i].n, vecs[i].en);
      step();
      check_all("vec", i, vecs[i].exp, vecs[i].exp);
    end

    // Reset during a pending update. Code 8 is registered, then code 2 is
    // presented and reset fires before the edge that would load it.
    drive(4'd8, 1'b1);
    step();
    check_all("mid_pre", 0, D8, D8);
    drive(4'd2, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check_all("mid_rst", 0, BL, D0);
    step();
    check_all("mid_held", 0, BL, D0);
    #2;
    rst = 1'b0;
    step();
    check_all("mid_resume", 0, D2, D2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a hang if the clock or the sequencing breaks.
  initial begin
    #100000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
